// File: rtl/cam_pkg.sv
// Shared constants and types for the CAM storage/search core.
package cam_pkg;

    localparam int CAM_DEPTH_DEF = 8;
    localparam int CAM_WIDTH_DEF = 4;

    // Selects whether a priority encoder reports the lowest or the highest set bit.
    typedef enum logic {
        PRIO_LOW  = 1'b0,
        PRIO_HIGH = 1'b1
    } prio_dir_e;

endpackage

// File: rtl/cam_if.sv
// Bus bundle for cam_array: direct write, invalidate, insert handshake,
// lookup request/response and occupancy flags.
// Optional feature macro: CAM_HIT_COUNT_EN adds rsp_hit_cnt.
interface cam_if
    import cam_pkg::*;
#(
    parameter int DEPTH = CAM_DEPTH_DEF,
    parameter int WIDTH = CAM_WIDTH_DEF
);
    localparam int AW = $clog2(DEPTH);

    logic             clr;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             inv_en;
    logic [AW-1:0]    inv_addr;
    logic             ins_valid;
    logic [WIDTH-1:0] ins_data;
    logic             ins_ready;
    logic [AW-1:0]    ins_addr;
    logic             lk_valid;
    logic [WIDTH-1:0] lk_key;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [AW-1:0]    rsp_min_addr;
    logic [AW-1:0]    rsp_max_addr;
    logic             full;
    logic             empty;
`ifdef CAM_HIT_COUNT_EN
    logic [AW:0]      rsp_hit_cnt;
`endif

    // The requester drives commands and observes responses.
    modport master (
        output clr, wr_en, wr_addr, wr_data, inv_en, inv_addr,
               ins_valid, ins_data, lk_valid, lk_key,
        input  ins_ready, ins_addr, rsp_valid, rsp_hit, rsp_min_addr,
               rsp_max_addr, full, empty
`ifdef CAM_HIT_COUNT_EN
        , input rsp_hit_cnt
`endif
    );

    // The CAM receives commands and produces responses.
    modport slave (
        input  clr, wr_en, wr_addr, wr_data, inv_en, inv_addr,
               ins_valid, ins_data, lk_valid, lk_key,
        output ins_ready, ins_addr, rsp_valid, rsp_hit, rsp_min_addr,
               rsp_max_addr, full, empty
`ifdef CAM_HIT_COUNT_EN
        , output rsp_hit_cnt
`endif
    );

endinterface

// File: rtl/cam_prio_enc.sv
// Priority encoder: index of the lowest (PRIO_LOW) or highest (PRIO_HIGH)
// set bit of an N-bit vector, plus an any-set flag. Index is 0 when no bit is set.
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int        N   = CAM_DEPTH_DEF,
    parameter prio_dir_e DIR = PRIO_LOW
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    // Scan so that the winning bit is the last one assigned.
    always_comb begin
        idx = '0;
        any = |vec;
        if (DIR == PRIO_LOW) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = IW'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cam_array.sv
// Clocked content-addressable memory with per-entry valid bits.
// Entries are loaded by direct write or auto-allocating insert; a registered
// lookup reports hit plus lowest and highest matching index.
// Optional feature macro: CAM_HIT_COUNT_EN adds a registered match count.
module cam_array
    import cam_pkg::*;
#(
    parameter int DEPTH = CAM_DEPTH_DEF,
    parameter int WIDTH = CAM_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    cam_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_nxt;
    logic [DEPTH-1:0] match;

    logic [AW-1:0]    min_idx;
    logic [AW-1:0]    max_idx;
    logic [AW-1:0]    free_idx;
    logic             min_any;
    logic             max_any;
    logic             free_any;
    logic             ins_ready;
    logic             ins_fire;

    logic             rsp_valid_q;
    logic             rsp_hit_q;
    logic [AW-1:0]    rsp_min_q;
    logic [AW-1:0]    rsp_max_q;

    // Compare the key against the current (pre-update) contents of every valid entry.
    always_comb begin
        match = '0;
        for (int e = 0; e < DEPTH; e++) begin
            match[e] = valid[e] && (mem[e] == bus.lk_key);
        end
    end

    cam_prio_enc #(.N(DEPTH), .DIR(PRIO_LOW)) u_min_enc (
        .vec (match),
        .idx (min_idx),
        .any (min_any)
    );

    cam_prio_enc #(.N(DEPTH), .DIR(PRIO_HIGH)) u_max_enc (
        .vec (match),
        .idx (max_idx),
        .any (max_any)
    );

    cam_prio_enc #(.N(DEPTH), .DIR(PRIO_LOW)) u_free_enc (
        .vec (~valid),
        .idx (free_idx),
        .any (free_any)
    );

    // Direct write and clear both block insert, so a single data write port suffices.
    assign ins_ready = free_any && !bus.clr && !bus.wr_en;
    assign ins_fire  = bus.ins_valid && ins_ready;

    // Valid bits: set by write/insert, overridden by invalidate, overridden again by clear.
    always_comb begin
        valid_nxt = valid;
        if (bus.wr_en) valid_nxt[bus.wr_addr] = 1'b1;
        if (ins_fire) valid_nxt[free_idx] = 1'b1;
        if (bus.inv_en) valid_nxt[bus.inv_addr] = 1'b0;
        if (bus.clr) valid_nxt = '0;
    end

    // Entry storage and valid bits; clear and invalidate never touch the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else begin
            valid <= valid_nxt;
            if (bus.wr_en) begin
                mem[bus.wr_addr] <= bus.wr_data;
            end else if (ins_fire) begin
                mem[free_idx] <= bus.ins_data;
            end
        end
    end

    // Lookup response register: strobe every cycle, result fields hold between lookups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_min_q   <= '0;
            rsp_max_q   <= '0;
        end else begin
            rsp_valid_q <= bus.lk_valid;
            if (bus.lk_valid) begin
                rsp_hit_q <= min_any | max_any;
                rsp_min_q <= min_idx;
                rsp_max_q <= max_idx;
            end
        end
    end

`ifdef CAM_HIT_COUNT_EN
    logic [AW:0] hit_cnt;
    logic [AW:0] rsp_hit_cnt_q;

    // Population count of the match vector.
    always_comb begin
        hit_cnt = '0;
        for (int e = 0; e < DEPTH; e++) begin
            hit_cnt = hit_cnt + (AW + 1)'(match[e]);
        end
    end

    // Match count registered alongside the hit flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_hit_cnt_q <= '0;
        end else if (bus.lk_valid) begin
            rsp_hit_cnt_q <= hit_cnt;
        end
    end

    assign bus.rsp_hit_cnt = rsp_hit_cnt_q;
`endif

    assign bus.ins_ready    = ins_ready;
    assign bus.ins_addr     = free_idx;
    assign bus.full         = !free_any;
    assign bus.empty        = !(|valid);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_hit      = rsp_hit_q;
    assign bus.rsp_min_addr = rsp_min_q;
    assign bus.rsp_max_addr = rsp_max_q;

endmodule
